// File: rtl/line_fifo_ctrl.sv
// Line FIFO controller: a RAM-backed entry queue with a one-cycle-latency read port
// feeding a two-entry skid buffer, so one entry per cycle is sustained both ways.
module line_fifo_ctrl #(
  parameter int NUMBER_OF_LINES = 16,
  parameter int DATA_WIDTH      = 128
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               ram_w_en,
  output logic [$clog2(NUMBER_OF_LINES)-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0]              ram_wr_data,
  output logic                               ram_r_en,
  output logic [$clog2(NUMBER_OF_LINES)-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0]              ram_rd_data,
  input  logic                               ram_rd_valid,
  output logic [$clog2(NUMBER_OF_LINES+3)-1:0] level
);

  localparam int AW = $clog2(NUMBER_OF_LINES);
  localparam int LW = $clog2(NUMBER_OF_LINES + 3);

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [1:0]            r_ob_cnt;
  logic                  r_inflight;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;

  logic [AW:0]           w_ram_cnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_rd;
  logic [2:0]            w_claim;

  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_ram_cnt == (AW+1)'(NUMBER_OF_LINES));
  assign w_empty   = (w_ram_cnt == '0);

  // r_run keeps in_ready (and thus writes) low while reset is held
  assign in_ready  = r_run & ~w_full & ~flush;
  assign out_valid = (r_ob_cnt != 2'd0);
  assign out_data  = r_ob0;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;
  assign w_load = ram_rd_valid & ~flush;

  // buffer slots already claimed once this cycle's pop is accounted for
  assign w_claim = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd    = ~w_empty & ~flush & (w_claim < 3'd2);

  assign ram_w_en    = w_push;
  assign ram_addr_w  = r_wr_ptr[AW-1:0];
  assign ram_wr_data = in_data;
  assign ram_r_en    = w_rd;
  assign ram_addr_r  = r_rd_ptr[AW-1:0];

  assign level = LW'(w_ram_cnt) + LW'(r_inflight) + LW'(r_ob_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ob_cnt   <= '0;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_ob_cnt   <= '0;
        r_inflight <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd)   r_rd_ptr <= r_rd_ptr + 1'b1;
        r_inflight <= w_rd;
        r_ob_cnt   <= r_ob_cnt + {1'b0, w_load} - {1'b0, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop && w_load) begin
      if (r_ob_cnt == 2'd2) begin
        r_ob0 <= r_ob1;
        r_ob1 <= ram_rd_data;
      end else begin
        r_ob0 <= ram_rd_data;
      end
    end else if (w_pop) begin
      r_ob0 <= r_ob1;
    end else if (w_load) begin
      if (r_ob_cnt == 2'd0) r_ob0 <= ram_rd_data;
      else                  r_ob1 <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Bench for line_fifo_ctrl: behavioural RAM plus a queue model of the stored entries.
module tb_line_fifo_ctrl;

  localparam int N  = 16;
  localparam int DW = 128;
  localparam int AW = $clog2(N);
  localparam int LW = $clog2(N + 3);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_w_en;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_wr_data;
  logic          ram_r_en;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_rd_data = '0;
  logic          ram_rd_valid = 1'b0;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_fail = 0;

  line_fifo_ctrl #(.NUMBER_OF_LINES(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_w_en(ram_w_en), .ram_addr_w(ram_addr_w), .ram_wr_data(ram_wr_data),
    .ram_r_en(ram_r_en), .ram_addr_r(ram_addr_r),
    .ram_rd_data(ram_rd_data), .ram_rd_valid(ram_rd_valid),
    .level(level)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr_w] <= ram_wr_data;
    ram_rd_valid <= ram_r_en;
    if (ram_r_en) ram_rd_data <= mem[ram_addr_r];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: every accepted entry not yet consumed, oldest first
  logic [DW-1:0] q[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          was_rst = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
      was_rst = 1'b1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ram_w_en", ram_w_en, 0);
      chk("rst_ram_r_en", ram_r_en, 0);
    end else begin
      chk("level_model", level, q.size());
      if (!was_rst && !flush && q.size() < N) chk("in_ready_not_full", in_ready, 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_pop", out_valid, 0);
        else chk("scoreboard_order", out_data, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
      if (flush) q.delete();
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      was_rst = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (level != 0 && k < 200) begin step(); k++; end
    chk("drain_timeout", level, 0);
  endtask

  task automatic basic_three();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 1;
    @(negedge clk);
    chk("c0_ram_w_en", ram_w_en, 1);
    chk("c0_ram_addr_w", ram_addr_w, 0);
    chk("c0_ram_wr_data", ram_wr_data, 1);
    chk("c0_ram_r_en", ram_r_en, 0);
    step(); in_data = 2;
    @(negedge clk);
    chk("c1_ram_r_en", ram_r_en, 1);
    chk("c1_ram_addr_r", ram_addr_r, 0);
    chk("c1_out_valid", out_valid, 0);
    step(); in_data = 3;
    @(negedge clk);
    chk("c2_out_valid", out_valid, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_data", out_data, 1);
    step();
    @(negedge clk);
    chk("c4_out_data", out_data, 2);
    step();
    @(negedge clk);
    chk("c5_out_data", out_data, 3);
    repeat (3) step();
    chk("basic_level_zero", level, 0);
    chk("basic_out_valid_zero", out_valid, 0);
  endtask

  initial begin
    int accepted, guard, pops, pushes, k;

    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_out_valid", out_valid, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_level", level, 0);

    basic_three();

    // fill with downstream stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    accepted = 0; guard = 0;
    while (accepted < 18 && guard < 40) begin
      in_data = rnd();
      @(negedge clk);
      if (in_ready) accepted++;
      step();
      guard++;
    end
    chk("fill_accepted", accepted, 18);
    in_data = rnd();
    @(negedge clk);
    chk("full_level", level, 18);
    chk("full_in_ready", in_ready, 0);
    repeat (2) step();
    chk("full_level_hold", level, 18);

    // from full, both sides streaming
    out_ready = 1'b1;
    pops = 0; pushes = 0;
    repeat (100) begin
      in_data = rnd();
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      if (in_valid && in_ready) pushes++;
      step();
    end
    chk("stream_pops", pops, 100);
    chk("stream_pushes", pushes, 99);

    // random traffic with random stalls
    repeat (300) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_data   = rnd();
      step();
    end
    drain();

    // flush while a RAM read is returning
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (11) begin in_data = rnd(); step(); end
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_flush_level", level, 11);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rd_valid", ram_rd_valid, 1);
    chk("flush_level", level, 10);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_level", level, 0);
    chk("post_flush_out_valid", out_valid, 0);
    step();
    in_valid = 1'b1; in_data = 'hAA;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 10) begin step(); @(negedge clk); k++; end
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_data", out_data, 'hAA);
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin in_data = rnd(); step(); end
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_level", level, 5);
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ram_w_en", ram_w_en, 0);
    chk("mid_rst_ram_r_en", ram_r_en, 0);
    repeat (3) step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst2_in_ready", in_ready, 1);
    basic_three();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
